// File: rtl/hilo_unit.sv
// HI/LO register file with multiply/divide sequencing for the multi-cycle MIPS core.
// MULT/MULTU use an internal shift-add multiplier; DIV/DIVU drive an external iterative divider.
module hilo_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_start,
   output logic             div_signed,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r,
   input  logic             div_done
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      MUL_RUN,
      MUL_FIX,
      DIV_START,
      DIV_WAIT
   } state_t;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_prod;
   logic               r_neg;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_dividend;
   logic [WIDTH-1:0]   r_divisor;
   logic               r_signed;

   logic               w_accept;
   logic               w_is_mul;
   logic               w_is_div;
   logic               w_div_zero;
   logic               w_mul_signed;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH:0]   w_shift;
   logic [2*WIDTH-1:0] w_prod_next;
   logic [2*WIDTH-1:0] w_prod_neg;

   assign w_accept     = (r_state == IDLE) && op_valid;
   assign w_is_mul     = (op_code == OP_MULT) || (op_code == OP_MULTU);
   assign w_is_div     = (op_code == OP_DIV) || (op_code == OP_DIVU);
   assign w_div_zero   = (op_b == '0);
   assign w_mul_signed = (op_code == OP_MULT);

   // Signed multiply runs on magnitudes; 0x80000000 negates to itself, which is its correct magnitude.
   assign w_abs_a = (w_mul_signed && op_a[WIDTH-1]) ? ('0 - op_a) : op_a;
   assign w_abs_b = (w_mul_signed && op_b[WIDTH-1]) ? ('0 - op_b) : op_b;

   // The carry of the upper-half add is kept and shifted back in, so the product never overflows.
   assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
   assign w_shift     = {w_sum, r_prod[WIDTH-1:0]};
   assign w_prod_next = r_mplier[0] ? w_shift[2*WIDTH:1] : {1'b0, r_prod[2*WIDTH-1:1]};
   assign w_prod_neg  = '0 - r_prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      busy      = (r_state != IDLE);
      div_start = (r_state == DIV_START);
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_is_mul)                     w_next = MUL_RUN;
               else if (w_is_div && !w_div_zero) w_next = DIV_START;
            end
         end
         MUL_RUN:   if (r_cnt == CW'(WIDTH-1)) w_next = MUL_FIX;
         MUL_FIX:   w_next = IDLE;
         DIV_START: w_next = DIV_WAIT;
         DIV_WAIT:  if (div_done) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_prod     <= '0;
         r_neg      <= 1'b0;
         r_cnt      <= '0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_signed   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  case (op_code)
                     OP_MULT, OP_MULTU: begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= w_mul_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        r_prod   <= '0;
                        r_cnt    <= '0;
                     end
                     OP_DIV, OP_DIVU: begin
                        if (w_div_zero) begin
                           r_hi   <= op_a;
                           r_lo   <= '1;
                           r_done <= 1'b1;
                        end else begin
                           r_dividend <= op_a;
                           r_divisor  <= op_b;
                           r_signed   <= (op_code == OP_DIV);
                        end
                     end
                     OP_MTHI: begin
                        r_hi   <= op_a;
                        r_done <= 1'b1;
                     end
                     OP_MTLO: begin
                        r_lo   <= op_a;
                        r_done <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            MUL_RUN: begin
               r_prod   <= w_prod_next;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
            end
            MUL_FIX: begin
               {r_hi, r_lo} <= r_neg ? w_prod_neg : r_prod;
               r_done       <= 1'b1;
            end
            DIV_WAIT: begin
               if (div_done) begin
                  r_lo   <= div_q;
                  r_hi   <= div_r;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign hi           = r_hi;
   assign lo           = r_lo;
   assign done         = r_done;
   assign div_signed   = r_signed;
   assign div_dividend = r_dividend;
   assign div_divisor  = r_divisor;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a behavioural 32-iteration divider attached.
module tb_hilo_unit;

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        div_done;

   int n_checks = 0;
   int n_errors = 0;
   int n_start_seen = 0;

   hilo_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
      .div_start(div_start), .div_signed(div_signed), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_q(div_q), .div_r(div_r), .div_done(div_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider model: starts on div_start (overriding busy), 32 busy cycles, no reset.
   logic m_busy = 1'b0;
   int   m_cnt  = 0;
   assign div_done = ~m_busy;

   always @(posedge clk) begin
      if (div_start) begin
         m_busy <= 1'b1;
         m_cnt  <= 32;
         if (div_divisor != 0) begin
            if (div_signed) begin
               div_q <= $signed(div_dividend) / $signed(div_divisor);
               div_r <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
               div_q <= div_dividend / div_divisor;
               div_r <= div_dividend % div_divisor;
            end
         end
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) m_busy <= 1'b0;
      end
   end

   always @(negedge clk) if (div_start) n_start_seen++;

   task automatic test_reset();
      rst_n = 1'b0; op_valid = 1'b0; op_code = 3'b000; op_a = '0; op_b = '0;
      #2;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if ({hi, lo} !== 64'h0) begin n_errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
      n_checks++; if (div_start !== 1'b0) begin n_errors++; $display("FAIL reset_div_start: got %b expected 0", div_start); end
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic run_mul(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
      int cyc = 0;
      int busy_n;
      bit seen = 0;
      op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
      @(posedge clk); #1;
      op_valid = 1'b0;
      busy_n = busy ? 1 : 0;
      while (!seen && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (done) seen = 1;
         else if (busy) busy_n++;
      end
      n_checks++; if (cyc !== 33) begin n_errors++; $display("FAIL %s_latency: got %0d expected 33", name, cyc); end
      n_checks++; if (busy_n !== 33) begin n_errors++; $display("FAIL %s_busy_cycles: got %0d expected 33", name, busy_n); end
      n_checks++; if (hi !== exp_hi) begin n_errors++; $display("FAIL %s_hi: got %h expected %h", name, hi, exp_hi); end
      n_checks++; if (lo !== exp_lo) begin n_errors++; $display("FAIL %s_lo: got %h expected %h", name, lo, exp_lo); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL %s_busy_end: got %b expected 0", name, busy); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL %s_done_pulse: got %b expected 0", name, done); end
   endtask

   task automatic test_mult();
      run_mul(3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg_a");
      run_mul(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
      run_mul(3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minneg");
      run_mul(3'b000, 32'h00000006, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF4, "mult_neg_b");
   endtask

   task automatic run_div(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
      int cyc = 0;
      int start_n;
      bit seen = 0;
      op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
      @(posedge clk); #1;
      op_valid = 1'b0;
      start_n = div_start ? 1 : 0;
      n_checks++; if (div_signed !== ~code[0]) begin n_errors++; $display("FAIL %s_signed: got %b expected %b", name, div_signed, ~code[0]); end
      while (!seen && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (div_start) start_n++;
         if (done) seen = 1;
      end
      n_checks++; if (cyc !== 34) begin n_errors++; $display("FAIL %s_latency: got %0d expected 34", name, cyc); end
      n_checks++; if (start_n !== 1) begin n_errors++; $display("FAIL %s_start_cycles: got %0d expected 1", name, start_n); end
      n_checks++; if (lo !== exp_lo) begin n_errors++; $display("FAIL %s_lo: got %h expected %h", name, lo, exp_lo); end
      n_checks++; if (hi !== exp_hi) begin n_errors++; $display("FAIL %s_hi: got %h expected %h", name, hi, exp_hi); end
      @(posedge clk); #1;
      n_checks++; if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL %s_idle_after: got %b expected 00", name, {busy, done}); end
   endtask

   task automatic test_div();
      run_div(3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
      run_div(3'b011, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, "divu");
   endtask

   task automatic test_div_zero();
      int starts0 = n_start_seen;
      op_valid = 1'b1; op_code = 3'b011; op_a = 32'd5; op_b = 32'd0;
      @(posedge clk); #1;
      op_valid = 1'b0;
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL divz_done: got %b expected 1", done); end
      n_checks++; if (hi !== 32'h00000005) begin n_errors++; $display("FAIL divz_hi: got %h expected 00000005", hi); end
      n_checks++; if (lo !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL divz_lo: got %h expected FFFFFFFF", lo); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL divz_busy: got %b expected 0", busy); end
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (n_start_seen !== starts0) begin n_errors++; $display("FAIL divz_start: got %0d strobes expected 0", n_start_seen - starts0); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL divz_done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_back_to_back();
      op_valid = 1'b1; op_code = 3'b100; op_a = 32'h12345678;
      @(posedge clk); #1;
      n_checks++; if (hi !== 32'h12345678) begin n_errors++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
      n_checks++; if ({busy, done} !== 2'b01) begin n_errors++; $display("FAIL mthi_flags: got %b expected 01", {busy, done}); end
      op_code = 3'b101; op_a = 32'h9ABCDEF0;
      @(posedge clk); #1;
      op_valid = 1'b0;
      n_checks++; if (lo !== 32'h9ABCDEF0) begin n_errors++; $display("FAIL mtlo_lo: got %h expected 9ABCDEF0", lo); end
      n_checks++; if (hi !== 32'h12345678) begin n_errors++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", hi); end
      n_checks++; if ({busy, done} !== 2'b01) begin n_errors++; $display("FAIL mtlo_flags: got %b expected 01", {busy, done}); end
      op_valid = 1'b1; op_code = 3'b110; op_a = 32'hAAAA5555;
      @(posedge clk); #1;
      op_valid = 1'b0;
      n_checks++; if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL unknown_flags: got %b expected 00", {busy, done}); end
      n_checks++; if ({hi, lo} !== 64'h12345678_9ABCDEF0) begin n_errors++; $display("FAIL unknown_hilo: got %h expected 123456789abcdef0", {hi, lo}); end
   endtask

   task automatic test_mtlo_while_busy();
      int cyc = 0;
      op_valid = 1'b1; op_code = 3'b001; op_a = 32'd3; op_b = 32'd5;
      @(posedge clk); #1;
      op_code = 3'b101; op_a = 32'hDEADBEEF;
      repeat (5) @(posedge clk);
      #1;
      op_valid = 1'b0;
      while (!done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL busy_mtlo_done: got %b expected 1", done); end
      n_checks++; if ({hi, lo} !== 64'h00000000_0000000F) begin n_errors++; $display("FAIL busy_mtlo_hilo: got %h expected 000000000000000f", {hi, lo}); end
      @(posedge clk); #1;
      n_checks++; if (lo !== 32'h0000000F) begin n_errors++; $display("FAIL busy_mtlo_lo_kept: got %h expected 0000000f", lo); end
   endtask

   task automatic test_reset_mid();
      op_valid = 1'b1; op_code = 3'b000; op_a = 32'h80000000; op_b = 32'd3;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL rstmid_flags: got %b expected 00", {busy, done}); end
      n_checks++; if ({hi, lo} !== 64'h0) begin n_errors++; $display("FAIL rstmid_hilo: got %h expected 0", {hi, lo}); end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      n_checks++; if ({busy, done, hi, lo} !== 66'h0) begin n_errors++; $display("FAIL rstmid_no_writeback: got %h expected 0", {busy, done, hi, lo}); end
      run_div(3'b011, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, "divu_after_rst");
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_back_to_back();
      test_mtlo_while_busy();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Multiply/divide controller and HI/LO register file for the multi-cycle MIPS core.
- Sits between the control unit/datapath (rs, rt operands) and the iterative divider (divCalculate).
- Executes MULT/MULTU with an internal 32-step shift-add multiplier.
- Sequences DIV/DIVU through the external divider, executes MTHI/MTLO, holds HI/LO, and raises busy so the control unit stalls.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operation request; sampled only while idle.
- op_code  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- op_a  in  32  rs operand (multiplicand / dividend / MTHI-MTLO data).
- op_b  in  32  rt operand (multiplier / divisor).
- busy  out  1  high while any multi-cycle op is in flight; combinational, state != IDLE.
- done  out  1  one-cycle registered pulse, high in the cycle HI/LO first show the new value.
- hi  out  32  HI register.
- lo  out  32  LO register.
- div_start  out  1  one-cycle start strobe to divider.
- div_signed  out  1  1 for DIV, 0 for DIVU; held stable from accept until writeback.
- div_dividend  out  32  registered op_a.
- div_divisor  out  32  registered op_b.
- div_q  in  32  divider quotient.
- div_r  in  32  divider remainder.
- div_done  in  1  divider idle flag, equal to ~busy of the divider.

Behaviour:
- Reset (async, rst_n low): state=IDLE, hi=lo=0, done=0, div_start=0, operand registers 0.
- Reset mid-operation aborts immediately; no HI/LO write.
- The divider has no reset. A later DIV still works because its start overrides its busy.
- States: IDLE, MUL_RUN, MUL_FIX, DIV_START, DIV_WAIT.
- Accept: at an edge with state=IDLE and op_valid=1. op_valid is ignored in any other state; the control unit must hold the op until busy is low.
- done defaults to 0 every edge. It is set to 1 only at the writeback edges listed below.
- MTHI/MTLO:
  - Accept edge writes op_a to hi/lo and sets done=1.
  - State stays IDLE; busy is never asserted.
- MULT/MULTU:
  - Accept edge (N): latch magnitudes, |x| only for MULT with a negative operand.
  - Also latch neg = MULT & (a[31]^b[31]), clear the 64-bit product, cnt=0, go to MUL_RUN.
  - MUL_RUN, edges N+1..N+32: if multiplier LSB, add multiplicand into product[63:32] with carry kept (33-bit add), then shift {carry, product} right by 1. cnt increments.
  - At cnt==31, go to MUL_FIX.
  - MUL_FIX, edge N+33: {hi,lo} = neg ? two's-complement(product) : product; done=1; go to IDLE.
  - Latency: 33 cycles accept-to-writeback.
- DIV/DIVU, op_b != 0:
  - Accept edge (N): latch div_dividend, div_divisor, div_signed; go to DIV_START.
  - div_start=1 exactly while state=DIV_START.
  - Edge N+1: go to DIV_WAIT.
  - DIV_WAIT: at the first edge with div_done=1, write lo=div_q and hi=div_r, set done=1, go to IDLE. With the 32-iteration divider this is edge N+34.
  - The divider's busy is already set at entry to DIV_WAIT, so a stale div_done cannot be sampled.
- DIV/DIVU, op_b == 0:
  - Divider is bypassed; div_start is never asserted.
  - Accept edge writes hi=op_a, lo=32'hFFFFFFFF, done=1; state stays IDLE.
- Unknown op_code with op_valid: no state change, no done.
- Arithmetic: full 64-bit product, no overflow. Most-negative operands (0x80000000) are handled via the unsigned magnitude path; -2^31 * -2^31 = 0x40000000_00000000.

Test Plan:
- MULT a=FFFFFFFD, b=00000007 -> busy 33 cycles; then hi=FFFFFFFF, lo=FFFFFFEB, done one cycle.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. MULT 80000000*80000000 -> hi=40000000, lo=0.
- With a behavioural divider model: DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 100/7 -> lo=0000000E, hi=00000002. In both: div_start high exactly one cycle, writeback at accept+34.
- DIVU 5/0 -> next cycle hi=00000005, lo=FFFFFFFF, done=1; busy and div_start never high.
- MTHI 12345678 then MTLO 9ABCDEF0 on consecutive cycles -> both written, busy stays 0. MTLO issued while a MULT is busy -> ignored, lo ends as the product.
- rst_n low 10 cycles into a MULT -> busy, done, hi, lo = 0 immediately. After release, DIVU 100/7 -> lo=0000000E, hi=00000002.
